bist_controller: RTL

- Sequences one scan-BIST session.
- Loads the serial random sequence generator (LFSR, serial output) with seed and polynomial, then shifts CHAIN_LEN bits per pattern into the scan chain and pulses capture.
- Compacts the shifted-out responses in a signature register, then compares the final signature with a golden value.
- Sits between the CPU/test-access registers and the generator, scan chain and compactor.

---
 rtl/bist_pkg.sv | 22 ++
 rtl/bist_controller_if.sv | 26 ++
 rtl/bist_pattern_counter.sv | 47 ++++
 rtl/bist_controller.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and width helpers for the scan-BIST session controller.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPTURE,
    FLUSH,
    COMPARE,
    DONE
  } state_t;

  function automatic int CNT_W(input int num_patterns);
    return $clog2(num_patterns + 1);
  endfunction

  function automatic int BIT_W(input int chain_len);
    return (chain_len < 2) ? 1 : $clog2(chain_len);
  endfunction

endpackage

// File: rtl/bist_controller_if.sv
// Controller-side bundle towards the pattern generator, scan chain and compactor.
interface bist_controller_if #(parameter int N = 8);

  logic         srsg_load;
  logic         srsg_en;
  logic [N-1:0] srsg_seed;
  logic [N-1:0] srsg_poly;
  logic         scan_en;
  logic         capture;
  logic         sisr_clr;
  logic         sisr_en;
  logic [N-1:0] sig_in;

  modport master (
    output srsg_load, srsg_en, srsg_seed, srsg_poly,
    output scan_en, capture, sisr_clr, sisr_en,
    input  sig_in
  );

  modport slave (
    input  srsg_load, srsg_en, srsg_seed, srsg_poly,
    input  scan_en, capture, sisr_clr, sisr_en,
    output sig_in
  );

endinterface

// File: rtl/bist_pattern_counter.sv
// Bit-in-chain and pattern counters with terminal-count flags for the BIST FSM.
module bist_pattern_counter
  import bist_pkg::*;
#(
  parameter int CHAIN_LEN    = 16,
  parameter int NUM_PATTERNS = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           bit_en,
  input  logic                           pat_inc,
  output logic [CNT_W(NUM_PATTERNS)-1:0] pattern_cnt,
  output logic                           shift_last,
  output logic                           pattern_last
);

  localparam int BW = BIT_W(CHAIN_LEN);
  localparam int PW = CNT_W(NUM_PATTERNS);

  logic [BW-1:0] bit_cnt;

  assign shift_last   = (bit_cnt == BW'(CHAIN_LEN - 1));
  assign pattern_last = (pattern_cnt == PW'(NUM_PATTERNS - 1));

  // The bit counter idles at zero so every SHIFT/FLUSH phase starts from bit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (bit_en && !shift_last) begin
      bit_cnt <= bit_cnt + BW'(1);
    end else begin
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern_cnt <= '0;
    end else if (clr) begin
      pattern_cnt <= '0;
    end else if (pat_inc) begin
      pattern_cnt <= pattern_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/bist_controller.sv
// Scan-BIST session sequencer: generator load, shift/capture loop, flush, signature compare.
// Optional abort input and aborted flag are built when BIST_ABORT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; latches seed/poly/golden on accept
// INIT    | load generator, clear compactor
// SHIFT   | shift CHAIN_LEN bits of one pattern
// CAPTURE | functional capture strobe, count pattern
// FLUSH   | unload last response into the compactor
// COMPARE | register signature match
// DONE    | one-cycle completion pulse
module bist_controller
  import bist_pkg::*;
#(
  parameter int N            = 8,
  parameter int CHAIN_LEN    = 16,
  parameter int NUM_PATTERNS = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [N-1:0]                   seed,
  input  logic [N-1:0]                   poly,
  input  logic [N-1:0]                   golden,
`ifdef BIST_ABORT_EN
  input  logic                           abort,
  output logic                           aborted,
`endif
  bist_controller_if.master              tst,
  output logic [CNT_W(NUM_PATTERNS)-1:0] pattern_cnt,
  output logic                           busy,
  output logic                           done,
  output logic                           pass
);

  state_t       state_q, state_d;
  logic [N-1:0] seed_q, poly_q, golden_q;
  logic         accept;
  logic         shift_last, pattern_last;

  assign accept = (state_q == IDLE) && start;

`ifdef BIST_ABORT_EN
  // DONE is excluded so a held abort cannot re-enter DONE and pulse twice.
  logic abort_hit;
  assign abort_hit = abort && (state_q != IDLE) && (state_q != DONE);
`endif

  bist_pattern_counter #(
    .CHAIN_LEN   (CHAIN_LEN),
    .NUM_PATTERNS(NUM_PATTERNS)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (accept),
    .bit_en      ((state_q == SHIFT) || (state_q == FLUSH)),
    .pat_inc     (state_q == CAPTURE),
    .pattern_cnt (pattern_cnt),
    .shift_last  (shift_last),
    .pattern_last(pattern_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    tst.srsg_load = 1'b0;
    tst.srsg_en   = 1'b0;
    tst.scan_en   = 1'b0;
    tst.capture   = 1'b0;
    tst.sisr_clr  = 1'b0;
    tst.sisr_en   = 1'b0;
    busy          = (state_q != IDLE);
    done          = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = INIT;
      INIT: begin
        tst.srsg_load = 1'b1;
        tst.sisr_clr  = 1'b1;
        state_d       = SHIFT;
      end
      SHIFT: begin
        tst.srsg_en = 1'b1;
        tst.scan_en = 1'b1;
        // First pattern unloads the chain's unknown power-up content.
        tst.sisr_en = (pattern_cnt != '0);
        if (shift_last) state_d = CAPTURE;
      end
      CAPTURE: begin
        tst.capture = 1'b1;
        state_d     = pattern_last ? FLUSH : SHIFT;
      end
      FLUSH: begin
        tst.scan_en = 1'b1;
        tst.sisr_en = 1'b1;
        if (shift_last) state_d = COMPARE;
      end
      COMPARE: state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef BIST_ABORT_EN
    if (abort_hit) state_d = DONE;
`endif
  end

  assign tst.srsg_seed = seed_q;
  assign tst.srsg_poly = poly_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      seed_q   <= '0;
      poly_q   <= '0;
      golden_q <= '0;
      pass     <= 1'b0;
`ifdef BIST_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else if (accept) begin
      seed_q   <= seed;
      poly_q   <= poly;
      golden_q <= golden;
      pass     <= 1'b0;
`ifdef BIST_ABORT_EN
      aborted  <= 1'b0;
    end else if (abort_hit) begin
      pass     <= 1'b0;
      aborted  <= 1'b1;
`endif
    end else if (state_q == COMPARE) begin
      pass <= (tst.sig_in == golden_q);
    end
  end

endmodule
